// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices and per-source stall/flush vectors for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int STG_PC      = 0;
  localparam int STG_IF2ID   = 1;
  localparam int STG_ID2EXE  = 2;
  localparam int STG_EXE2MEM = 3;
  localparam int STG_MEM2WB  = 4;

  typedef logic [4:0] stage_vec_t;

  // Each source holds everything upstream of its stage and bubbles the register just downstream.
  localparam stage_vec_t EXC_STALL = '0;
  localparam stage_vec_t EXC_FLUSH = stage_vec_t'((1 << STG_IF2ID) | (1 << STG_ID2EXE) |
                                                  (1 << STG_EXE2MEM) | (1 << STG_MEM2WB));
  localparam stage_vec_t MEM_STALL = stage_vec_t'((1 << STG_PC) | (1 << STG_IF2ID) |
                                                  (1 << STG_ID2EXE) | (1 << STG_EXE2MEM));
  localparam stage_vec_t MEM_FLUSH = stage_vec_t'(1 << STG_MEM2WB);
  localparam stage_vec_t DIV_STALL = stage_vec_t'((1 << STG_PC) | (1 << STG_IF2ID) |
                                                  (1 << STG_ID2EXE));
  localparam stage_vec_t DIV_FLUSH = stage_vec_t'(1 << STG_EXE2MEM);
  localparam stage_vec_t LU_STALL  = stage_vec_t'((1 << STG_PC) | (1 << STG_IF2ID));
  localparam stage_vec_t LU_FLUSH  = stage_vec_t'(1 << STG_ID2EXE);

endpackage

// File: rtl/div_timer.sv
// Occupancy timer for the multi-cycle divider: holds the pipeline for DIV_CYCLES cycles, then pulses done.
module div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  output logic div_stall_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic          start_ok;

  // Start is only sampled while idle, so the held level is ignored on the done cycle.
  assign start_ok    = ~busy_q & start_i & ~abort_i;
  assign div_stall_o = start_ok | (busy_q & (cnt_q != '0));
  assign done_o      = busy_q & (cnt_q == '0) & ~abort_i & ~rst_i;
  assign busy_o      = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_ok) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_LOAD;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: exception > memory wait > divide > load-use, one source per cycle.
// Optional stall-cycle counter enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_rmem_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_div_start_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        except_valid_i,
  input  logic [31:0] except_target_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        div_busy_o,
  output logic        div_done_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  logic div_stall;
  logic mem_wait;
  logic load_use;

  div_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (ex_div_start_i),
    .abort_i     (except_valid_i),
    .div_stall_o (div_stall),
    .busy_o      (div_busy_o),
    .done_o      (div_done_o)
  );

  assign mem_wait = mem_req_i & ~mem_ack_i;
  // $0 is hardwired, so a load targeting it can never create a dependency.
  assign load_use = ex_rmem_i & (ex_waddr_i != 5'd0) &
                    ((ex_waddr_i == id_rs_i) | (ex_waddr_i == id_rt_i));

  always_comb begin
    stall_o       = '0;
    flush_o       = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    if (except_valid_i) begin
      stall_o       = EXC_STALL;
      flush_o       = EXC_FLUSH;
      redirect_o    = 1'b1;
      redirect_pc_o = except_target_i;
    end else if (mem_wait) begin
      stall_o = MEM_STALL;
      flush_o = MEM_FLUSH;
    end else if (div_stall) begin
      stall_o = DIV_STALL;
      flush_o = DIV_FLUSH;
    end else if (load_use) begin
      stall_o = LU_STALL;
      flush_o = LU_FLUSH;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
    end else if (stall_o[STG_PC]) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences, random vs. reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIV_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_waddr = '0;
  logic        ex_rmem = 1'b0, ex_div_start = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic        except_valid = 1'b0;
  logic [31:0] except_target = '0;
  logic [4:0]  stall, flush;
  logic        redirect, div_busy, div_done;
  logic [31:0] redirect_pc;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_N)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .ex_rmem_i       (ex_rmem),
    .ex_waddr_i      (ex_waddr),
    .ex_div_start_i  (ex_div_start),
    .mem_req_i       (mem_req),
    .mem_ack_i       (mem_ack),
    .except_valid_i  (except_valid),
    .except_target_i (except_target),
    .stall_o         (stall),
    .flush_o         (flush),
    .redirect_o      (redirect),
    .redirect_pc_o   (redirect_pc),
    .div_busy_o      (div_busy),
    .div_done_o      (div_done)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .stall_cycles_o  (stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a divide is remembered by the cycle number it started in.
  int          cyc = 0;
  int          start_cyc = -1;
  logic [31:0] perf_ref = '0;
  logic [4:0]  e_stall, e_flush;
  logic        e_red, e_busy, e_done, e_started;
  logic [31:0] e_pc;

  task automatic model_eval();
    int  off;
    bit  lu, dstall;
    off       = cyc - start_cyc;
    e_busy    = (start_cyc >= 0) && off >= 1 && off <= DIV_N;
    e_started = !e_busy && ex_div_start && !except_valid;
    dstall    = e_started || (e_busy && off < DIV_N);
    e_done    = e_busy && off == DIV_N && !except_valid && !rst;
    lu        = ex_rmem && ex_waddr != 5'd0 && (ex_waddr == id_rs || ex_waddr == id_rt);
    e_stall = 5'b00000; e_flush = 5'b00000; e_red = 1'b0; e_pc = 32'd0;
    if (except_valid) begin
      e_flush = 5'b11110; e_red = 1'b1; e_pc = except_target;
    end else if (mem_req && !mem_ack) begin
      e_stall = 5'b01111; e_flush = 5'b10000;
    end else if (dstall) begin
      e_stall = 5'b00111; e_flush = 5'b01000;
    end else if (lu) begin
      e_stall = 5'b00011; e_flush = 5'b00100;
    end
  endtask

  task automatic eval_cmp(input bit check, input string tag);
    model_eval();
    if (check) begin
      chk({tag, ".stall"},    32'(stall),    32'(e_stall));
      chk({tag, ".flush"},    32'(flush),    32'(e_flush));
      chk({tag, ".redirect"}, 32'(redirect), 32'(e_red));
      chk({tag, ".pc"},       redirect_pc,   e_pc);
      chk({tag, ".busy"},     32'(div_busy), 32'(e_busy));
      chk({tag, ".done"},     32'(div_done), 32'(e_done));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) perf_ref = '0;
    else if (e_stall[0]) perf_ref = perf_ref + 32'd1;
    if (rst || except_valid) start_cyc = -1;
    else if (e_started) start_cyc = cyc;
    cyc++;
    #1;
  endtask

  task automatic tick(input string tag);
    #2;
    eval_cmp(1'b1, tag);
    adv();
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_waddr = '0; ex_rmem = 1'b0; ex_div_start = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; except_valid = 1'b0; except_target = '0;
  endtask

  typedef struct {
    logic [4:0]  rs, rt, waddr;
    logic        rmem, req, ack, exc;
    logic [31:0] tgt;
    logic [4:0]  st, fl;
    logic        red;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 5'b00000, 1'b0};
    tbl[1]  = '{5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00011, 5'b00100, 1'b0};
    tbl[2]  = '{5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00011, 5'b00100, 1'b0};
    tbl[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 5'b00000, 1'b0};
    tbl[4]  = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 5'b00000, 1'b0};
    tbl[5]  = '{5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        5'b00000, 5'b00000, 1'b0};
    tbl[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'b01111, 5'b10000, 1'b0};
    tbl[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        5'b00000, 5'b00000, 1'b0};
    tbl[8]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        5'b01111, 5'b10000, 1'b0};
    tbl[9]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00380, 5'b00000, 5'b11110, 1'b1};
    tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80000180, 5'b00000, 5'b11110, 1'b1};
    tbl[11] = '{5'd7, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        5'b00011, 5'b00100, 1'b0};

    // Reset
    idle_inputs();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      #2; eval_cmp(1'b0, "rst"); adv();
    end
    rst = 1'b0;
    #2;
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.flush", 32'(flush), 32'd0);
    chk("reset.busy",  32'(div_busy), 32'd0);
    chk("reset.done",  32'(div_done), 32'd0);
    eval_cmp(1'b1, "reset");
    adv();

    // Combinational priority table (divider idle)
    for (int i = 0; i < 12; i++) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_waddr = tbl[i].waddr; ex_rmem = tbl[i].rmem;
      mem_req = tbl[i].req; mem_ack = tbl[i].ack; except_valid = tbl[i].exc;
      except_target = tbl[i].tgt; ex_div_start = 1'b0;
      #2;
      chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d.red", i), 32'(redirect), 32'(tbl[i].red));
      chk($sformatf("tbl%0d.pc", i), redirect_pc, tbl[i].red ? tbl[i].tgt : 32'd0);
      eval_cmp(1'b0, "tbl");
      adv();
    end
    idle_inputs();

    // Load-use: one stall cycle, then release
    ex_rmem = 1'b1; ex_waddr = 5'd5; id_rt = 5'd5;
    #2; chk("lu.stall", 32'(stall), 32'b00011); chk("lu.flush", 32'(flush), 32'b00100);
    eval_cmp(1'b1, "lu"); adv();
    idle_inputs();
    tick("lu_after");

    // Memory wait for 3 cycles, ack on the 4th
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2; chk($sformatf("memw%0d.stall", i), 32'(stall), 32'b01111);
      eval_cmp(1'b1, "memw"); adv();
    end
    mem_ack = 1'b1;
    #2; chk("memack.stall", 32'(stall), 32'd0); chk("memack.flush", 32'(flush), 32'd0);
    eval_cmp(1'b1, "memack"); adv();
    idle_inputs();

    // Divide with DIV_CYCLES=4
    ex_div_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #2;
      chk($sformatf("div%0d.stall", k), 32'(stall), (k <= 4) ? 32'b00111 : 32'd0);
      chk($sformatf("div%0d.done", k), 32'(div_done), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("div%0d.busy", k), 32'(div_busy), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      eval_cmp(1'b1, "div");
      adv();
      if (k == 5) ex_div_start = 1'b0;
    end

    // Exception in cycle 2 of a divide
    ex_div_start = 1'b1;
    tick("exdiv1");
    except_valid = 1'b1; except_target = 32'hBFC00380;
    #2;
    chk("exdiv.flush", 32'(flush), 32'b11110);
    chk("exdiv.pc", redirect_pc, 32'hBFC00380);
    chk("exdiv.done", 32'(div_done), 32'd0);
    eval_cmp(1'b1, "exdiv2"); adv();
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("exdiv_post%0d.busy", k), 32'(div_busy), 32'd0);
      chk($sformatf("exdiv_post%0d.done", k), 32'(div_done), 32'd0);
      eval_cmp(1'b1, "exdiv_post"); adv();
    end

    // Simultaneous mem wait + load-use + divide: count keeps running under the mem stall
    ex_div_start = 1'b1;
    tick("sim1");
    mem_req = 1'b1; ex_rmem = 1'b1; ex_waddr = 5'd4; id_rs = 5'd4;
    for (int k = 2; k <= 3; k++) begin
      #2; chk($sformatf("sim%0d.stall", k), 32'(stall), 32'b01111);
      chk($sformatf("sim%0d.flush", k), 32'(flush), 32'b10000);
      eval_cmp(1'b1, "sim"); adv();
    end
    mem_req = 1'b0; ex_rmem = 1'b0;
    #2; chk("sim4.stall", 32'(stall), 32'b00111); eval_cmp(1'b1, "sim4"); adv();
    #2; chk("sim5.done", 32'(div_done), 32'd1); eval_cmp(1'b1, "sim5"); adv();
    idle_inputs();
    tick("sim6");

    // Back-to-back divides with start held throughout
    ex_div_start = 1'b1;
    for (int k = 1; k <= 10; k++) tick($sformatf("b2b%0d", k));
    ex_div_start = 1'b0;
    tick("b2b_end");

    // Reset mid-divide: no done pulse afterwards
    ex_div_start = 1'b1;
    tick("rdiv1"); tick("rdiv2");
    ex_div_start = 1'b0; rst = 1'b1;
    #2; eval_cmp(1'b0, "rdiv_rst"); adv();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #2; chk($sformatf("rdiv_post%0d.done", k), 32'(div_done), 32'd0);
      eval_cmp(1'b1, "rdiv_post"); adv();
    end

    // Random stimulus against the reference model
    for (int n = 0; n < 800; n++) begin
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_waddr      = 5'($urandom_range(0, 3));
      ex_rmem       = ($urandom_range(0, 2) == 0);
      ex_div_start  = ($urandom_range(0, 2) == 0);
      mem_req       = ($urandom_range(0, 3) == 0);
      mem_ack       = ($urandom_range(0, 1) == 0);
      except_valid  = ($urandom_range(0, 31) == 0);
      except_target = $urandom;
      tick("rnd");
    end
    idle_inputs();
    tick("final");

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    #2;
    chk("perf", stall_cycles, perf_ref);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the `stall_i`/`flush_i` inputs of the PC register and the if2id, id2exe, exe2mem and mem2wb pipeline registers. It resolves four hazard sources into one consistent control vector per cycle:

- exceptions
- data-memory wait states
- multi-cycle divide occupancy
- load-use hazards

## Interface
Parameters:
- DIV_CYCLES, 32, stall cycles per divide; legal range ≥2.

Ports. Stall/flush vectors are indexed 0=PC, 1=if2id, 2=id2exe, 3=exe2mem, 4=mem2wb.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- id_rs_i  in  5  rs register number of the instruction in ID
- id_rt_i  in  5  rt register number of the instruction in ID
- ex_rmem_i  in  1  the instruction in EX is a load
- ex_waddr_i  in  5  destination register of the instruction in EX
- ex_div_start_i  in  1  a DIV/DIVU is in EX; level signal held while the instruction sits in EX
- mem_req_i  in  1  the instruction in MEM issues a data-bus access (memen)
- mem_ack_i  in  1  data-bus completion, same cycle as the access
- except_valid_i  in  1  exception committed in MEM
- except_target_i  in  32  handler PC
- stall_o  out  5  per-register hold
- flush_o  out  5  per-register bubble; the register gives flush priority over stall
- redirect_o  out  1  load except_target into PC
- redirect_pc_o  out  32  redirect target
- div_busy_o  out  1  divider timer running
- div_done_o  out  1  one-cycle pulse; the quotient is valid this cycle

## Operation
Per cycle, select the first active source below. Only the selected source's vector is driven; vectors are never OR-ed.

1. **Exception** (except_valid_i):
   - flush_o=11110, stall_o=00000, redirect_o=1, redirect_pc_o=except_target_i.
   - Clears the divider timer at the edge.
   - mem_ack_i is ignored.
2. **Memory wait** (mem_req_i & ~mem_ack_i):
   - stall_o=01111, flush_o=10000.
3. **Divide** (div_stall):
   - stall_o=00111, flush_o=01000.
4. **Load-use**: ex_rmem_i & ex_waddr_i≠0 & (ex_waddr_i==id_rs_i | ex_waddr_i==id_rt_i):
   - stall_o=00011, flush_o=00100.
5. **None**: all zero, redirect_o=0, redirect_pc_o=0.

Divider timer, with state busy_q and cnt_q of width $clog2(DIV_CYCLES):
- **Idle, start seen** (busy_q=0, ex_div_start_i=1, no exception):
  - div_stall=1 combinationally.
  - At the edge: cnt_q←DIV_CYCLES-1, busy_q←1.
- **Busy, counting** (busy_q=1, cnt_q≠0):
  - div_stall=1, cnt_q decrements each cycle.
  - The count continues while a memory-wait stall is selected.
- **Busy, final cycle** (busy_q=1, cnt_q=0):
  - div_done_o=1, div_stall=0, busy_q←0.
  - The divide advances out of EX at this edge. ex_div_start_i is not re-sampled this cycle.
- div_busy_o=busy_q.
- Exception in any state: busy_q←0, cnt_q←0, no div_done_o.

## Timing
- Reset: stall_o=0, flush_o=0, redirect_o=0, redirect_pc_o=0, div_busy_o=0, div_done_o=0, busy_q=0, cnt_q=0. Perf counter=0.
- Reset mid-divide aborts the divide; no done pulse is produced.
- All outputs are combinational from inputs and registered state. No input-to-state latency beyond one edge.
- A divide gives exactly DIV_CYCLES stall cycles: the start cycle plus cnt_q=DIV_CYCLES-1..1.
- div_done_o follows the last stall cycle.
- A memory wait lasts exactly as long as ack is low. With ack in the same cycle as the request, there is zero stall.
- A load-use hazard gives exactly one stall cycle, because the load leaves EX at the next edge.
- Register $0 never triggers load-use.
- Back-to-back divides: the second start is accepted the cycle after done, when busy_q=0.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - Adds output stall_cycles_o[31:0].
  - Increments on every cycle with stall_o[0]=1, wraps at 2^32, reset to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - constants STG_PC=0, STG_IF2ID=1, STG_ID2EXE=2, STG_EXE2MEM=3, STG_MEM2WB=4
  - typedef stage_vec_t (logic [4:0])
  - the four source vectors as localparams (EXC_FLUSH, MEM_STALL, DIV_STALL, LU_STALL and their flush counterparts)
- Sub-module div_timer holds busy_q/cnt_q and produces div_stall, div_busy_o and div_done_o. It takes start, abort and DIV_CYCLES.

## Test plan
- **Load-use:** ex_rmem_i=1, ex_waddr_i=5, id_rt_i=5 for one cycle -> stall_o=00011, flush_o=00100 for one cycle. Repeating with ex_waddr_i=0 -> all zero.
- **Memory wait:** mem_req_i=1, ack low for 3 cycles -> stall_o=01111, flush_o=10000 for 3 cycles. Ack on the 4th cycle -> outputs return to 0.
- **Divide:** ex_div_start_i held with DIV_CYCLES=4 -> stall_o=00111 for 4 cycles, div_done_o on the 5th cycle, div_busy_o high cycles 2-5.
- **Exception mid-divide:** except_valid_i at cycle 2 of a divide, target 0xBFC00380 -> flush_o=11110, redirect_pc_o=0xBFC00380, div_busy_o=0 next cycle, no div_done_o.
- **Simultaneous sources:** memory wait, load-use hazard and divide busy all active at once -> MEM_STALL vector only; the divide count keeps decrementing.
- **Perf counter** (PIPE_HAZARD_CTRL_PERF_EN defined): after the scenarios above, stall_cycles_o equals the number of cycles with stall_o[0]=1. With the macro undefined, the port is absent and the design still compiles.
